fpu_op_sequencer: RTL

- Sequences one FPU operation from a narrow word stream: captures operand A, operand B and opcode as three words on consecutive accepted beats.
- Holds the operands stable, pulses the FPU start, waits for done with a timeout guard, then presents the result with a valid/ack handshake.
- Sits between the chip-level input pins and the FPU datapath. Replaces ad-hoc input/output buffering with one FSM.

---
 rtl/fpu_op_sequencer_if.sv | 30 +++
 rtl/fpu_op_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/fpu_op_sequencer_if.sv
// rtl/fpu_op_sequencer_if.sv - word stream, FPU and result handshake bundle for the op sequencer
interface fpu_op_sequencer_if #(
    parameter int WIDTH = 10,
    parameter int OP_W  = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] fpu_a;
    logic [WIDTH-1:0] fpu_b;
    logic [OP_W-1:0]  fpu_op;
    logic             fpu_start;
    logic             fpu_done;
    logic [WIDTH-1:0] fpu_y;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_ack;
    logic             busy;
    logic             err;
    logic             overrun;

    modport master (
        input  in_valid, in_data, fpu_done, fpu_y, res_ack,
        output fpu_a, fpu_b, fpu_op, fpu_start, res_valid, res_data, busy, err, overrun
    );

    modport slave (
        output in_valid, in_data, fpu_done, fpu_y, res_ack,
        input  fpu_a, fpu_b, fpu_op, fpu_start, res_valid, res_data, busy, err, overrun
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - captures A/B/opcode words, issues one FPU op with timeout, hands back result
module fpu_op_sequencer #(
    parameter int WIDTH   = 10,
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    fpu_op_sequencer_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, GET_B, GET_OP, ISSUE, WAIT, RESULT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] res_q;
    logic             err_q;
    logic             ovr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            res_q <= '0;
            err_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.in_data;
                        err_q <= 1'b0;
                        ovr_q <= 1'b0;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (bus.in_valid) begin
                        b_q   <= bus.in_data;
                        state <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.in_data[OP_W-1:0];
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.in_valid) ovr_q <= 1'b1;
                    // A combinational FPU may answer in the same cycle as start.
                    if (bus.fpu_done) begin
                        res_q <= bus.fpu_y;
                        state <= RESULT;
                    end else begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.in_valid) ovr_q <= 1'b1;
                    if (bus.fpu_done) begin
                        res_q <= bus.fpu_y;
                        state <= RESULT;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= cnt + 1'b1;
                        res_q <= '1;
                        err_q <= 1'b1;
                        state <= RESULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.in_valid) ovr_q <= 1'b1;
                    if (bus.res_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fpu_a     = a_q;
    assign bus.fpu_b     = b_q;
    assign bus.fpu_op    = op_q;
    assign bus.fpu_start = (state == ISSUE);
    assign bus.res_valid = (state == RESULT);
    assign bus.res_data  = res_q;
    assign bus.busy      = (state != IDLE);
    assign bus.err       = err_q;
    assign bus.overrun   = ovr_q;
endmodule
